bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Converts a packed 4-digit BCD value (thousands..units) into an N-bit binary number.
//  It is the reverse path of the binary->BCD/7-segment display chain, used for switch- or keypad-entered decimal values.
//  Sequential multiply-by-10 accumulator, one digit per clock.
//  valid/ready handshake on both the input and output sides.
// PARAMETERS
//  N       10   output binary width; 9999 needs 14 bits, so smaller N can overflow
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous reset, active-low
//  bcd_in     in   16    [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=units
//  in_valid   in   1     bcd_in is valid
//  in_ready   out  1     block can accept a value (high only in IDLE)
//  bin_out    out  N     converted result
//  ovf        out  1     value > 2^N-1
//  err        out  1     some digit > 9
//  out_valid  out  1     bin_out/ovf/err are valid
//  out_ready  in   1     consumer accepts the result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; bin_out=0, ovf=0, err=0, out_valid=0, in_ready=1.
//    Applies immediately, including mid-conversion; the partial result is discarded.
//  States: IDLE -> CONV -> DONE -> IDLE.
//  IDLE
//   - in_ready=1.
//   - On in_valid&in_ready: latch bcd_in, acc=0, idx=3, err_r=0, go to CONV.
//  CONV (exactly 4 cycles)
//   - Each cycle: acc <= acc*10 + digit[idx]; idx decrements.
//   - acc is 14 bits; no internal wrap.
//   - err_r |= (digit[idx] > 9).
//   - After idx=0, go to DONE.
//  DONE
//   - out_valid=1; outputs are held stable until out_valid&out_ready, then return to IDLE.
//   - in_ready stays 0 in DONE. A new accept is possible on the cycle after the handshake.
//  Latency: out_valid rises on the 5th rising edge after the accepting edge (4 CONV edges + registering into DONE).
//  Output rules in DONE
//   - err=1: bin_out=0 and ovf=0 (error takes priority).
//   - otherwise: ovf = (acc > 2^N-1); bin_out per CONFIGURATION.
//   - If N >= 14, ovf is tied to 0 and bin_out = zero-extended acc.
//  in_valid while in CONV/DONE is ignored (the value is not latched).
//  bin_out, ovf and err keep their last values while not in DONE; only out_valid qualifies them.
// CONFIGURATION
//  BCD_SAT_EN defined:     on ovf=1, bin_out = {N{1'b1}} (saturate).
//  BCD_SAT_EN not defined: on ovf=1, bin_out = acc[N-1:0] (modulo 2^N).
//  ovf is reported identically in both builds.
// STRUCTURE
//  Shared package/include bcd_pkg:
//   - state encoding (S_IDLE, S_CONV, S_DONE)
//   - BCD_DIGITS=4, BCD_ACC_W=14, BCD_DIGIT_MAX=4'd9
//  One sub-module: bcd_digit_mac (combinational).
//   - Inputs: acc[13:0], digit[3:0].
//   - Outputs: acc*10+digit (as (acc<<3)+(acc<<1)+digit), digit_bad.
//  Top: FSM, idx counter, operand/acc registers, output mux.
// TESTING
//  1. bcd_in=16'h1023, out_ready=1 -> out_valid 5 edges after accept; bin_out=1023, ovf=0, err=0.
//  2. bcd_in=16'h9999, N=10 -> ovf=1; bin_out=783 without BCD_SAT_EN, 1023 with it.
//  3. bcd_in=16'h12A4 -> err=1, bin_out=0, ovf=0.
//  4. out_ready=0 for 10 cycles in DONE -> out_valid stays 1, bin_out stable, in_ready=0;
//     a new in_valid pulse is not accepted.
//  5. rst_n low during 2nd CONV cycle -> outputs 0 and in_ready=1 immediately;
//     after release, bcd_in=16'h0042 -> bin_out=42.
//  6. Back-to-back 16'h0000 then 16'h0999 -> bin_out=0 then 999; second accept on the cycle after the first output handshake.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int         BCD_DIGITS    = 4;
  localparam int         BCD_ACC_W     = 14;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_mac.sv
// One accumulate step: acc*10 + digit, computed with shifts, plus a digit range check.
module bcd_digit_mac
  import bcd_pkg::*;
(
  input  logic [BCD_ACC_W-1:0] acc,
  input  logic [3:0]           digit,
  output logic [BCD_ACC_W-1:0] acc_next,
  output logic                 digit_bad
);

  assign acc_next  = (acc << 3) + (acc << 1) + {{(BCD_ACC_W-4){1'b0}}, digit};
  assign digit_bad = (digit > BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to N-bit binary converter with valid/ready on both sides.
// Build option: define BCD_SAT_EN to saturate bin_out on overflow instead of wrapping.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  bcd_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] bin_out,
  output logic         ovf,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t               state_r;
  logic [1:0]           idx_r;
  logic [15:0]          operand_r;
  logic [BCD_ACC_W-1:0] acc_r;
  logic                 err_acc_r;
  logic [N-1:0]         bin_r;
  logic                 ovf_r;
  logic                 err_r;
  logic                 out_valid_r;
  logic                 in_ready_r;

  logic [3:0]           digit_s;
  logic [BCD_ACC_W-1:0] acc_next_s;
  logic                 digit_bad_s;
  logic [N-1:0]         bin_conv_s;
  logic                 ovf_conv_s;
  logic [N-1:0]         bin_s;
  logic                 ovf_s;

  assign digit_s = operand_r[{idx_r, 2'b00} +: 4];

  bcd_digit_mac u_mac (
    .acc       (acc_r),
    .digit     (digit_s),
    .acc_next  (acc_next_s),
    .digit_bad (digit_bad_s)
  );

  // Wide outputs can always hold 9999; narrower ones need range handling.
  generate
    if (N >= BCD_ACC_W) begin : g_wide
      assign ovf_conv_s = 1'b0;
      assign bin_conv_s = N'(acc_r);
    end else begin : g_narrow
      localparam logic [BCD_ACC_W-1:0] BIN_MAX = BCD_ACC_W'((2**N) - 1);
      assign ovf_conv_s = (acc_r > BIN_MAX);
`ifdef BCD_SAT_EN
      assign bin_conv_s = ovf_conv_s ? {N{1'b1}} : acc_r[N-1:0];
`else
      assign bin_conv_s = acc_r[N-1:0];
`endif
    end
  endgenerate

  // Result mux: a bad digit forces a zero result with no overflow flag.
  always_comb begin
    bin_s = '0;
    ovf_s = 1'b0;
    if (err_acc_r) begin
      bin_s = '0;
      ovf_s = 1'b0;
    end else begin
      bin_s = bin_conv_s;
      ovf_s = ovf_conv_s;
    end
  end

  // Control FSM: accept in IDLE, four digit steps in CONV, result register and handshake in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= 2'd0;
      operand_r   <= 16'd0;
      acc_r       <= '0;
      err_acc_r   <= 1'b0;
      bin_r       <= '0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            operand_r  <= bcd_in;
            acc_r      <= '0;
            idx_r      <= 2'(BCD_DIGITS - 1);
            err_acc_r  <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= S_CONV;
          end
        end
        S_CONV: begin
          acc_r     <= acc_next_s;
          err_acc_r <= err_acc_r | digit_bad_s;
          idx_r     <= idx_r - 2'd1;
          if (idx_r == 2'd0) begin
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle registers the result; it is then held until taken.
          if (!out_valid_r) begin
            bin_r       <= bin_s;
            ovf_r       <= ovf_s;
            err_r       <= err_acc_r;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign bin_out   = bin_r;
  assign ovf       = ovf_r;
  assign err       = err_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (N=10); expectations follow BCD_SAT_EN.
module tb_bcd_to_bin;

  localparam int N = 10;

  logic         clk;
  logic         rst_n;
  logic [15:0]  bcd_in;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] bin_out;
  logic         ovf;
  logic         err;
  logic         out_valid;
  logic         out_ready;

  int pass_cnt;
  int total_cnt;

  bcd_to_bin #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_conv(input logic [15:0] v, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bcd_in   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bcd_in = 16'h0000;
    #12;
    total_cnt++;
    if ({out_valid, in_ready, ovf, err, bin_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 10'd0})
      $display("FAIL reset_state: valid=%0b ready=%0b ovf=%0b err=%0b bin=%0d", out_valid, in_ready, ovf, err, bin_out);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b0;
    start_conv(16'h1023, lat);
    total_cnt++;
    if (lat !== 5) $display("FAIL basic_latency: got %0d want 5", lat); else pass_cnt++;
    total_cnt++;
    if ({bin_out, ovf, err, in_ready} !== {10'd1023, 1'b0, 1'b0, 1'b0})
      $display("FAIL basic_result: bin=%0d ovf=%0b err=%0b ready=%0b want 1023/0/0/0", bin_out, ovf, err, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL basic_handshake: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int lat;
    logic [N-1:0] exp_bin;
`ifdef BCD_SAT_EN
    exp_bin = 10'd1023;
`else
    exp_bin = 10'd783;
`endif
    out_ready = 1'b0;
    start_conv(16'h9999, lat);
    total_cnt++;
    if ({bin_out, ovf, err} !== {exp_bin, 1'b1, 1'b0})
      $display("FAIL overflow: bin=%0d ovf=%0b err=%0b want %0d/1/0", bin_out, ovf, err, exp_bin);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    // 1023 is the largest value that fits exactly
    out_ready = 1'b0;
    start_conv(16'h1023, lat);
    total_cnt++;
    if ({bin_out, ovf} !== {10'd1023, 1'b0})
      $display("FAIL edge_1023: bin=%0d ovf=%0b want 1023/0", bin_out, ovf);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_conv(16'h1024, lat);
    total_cnt++;
    if ({bin_out, ovf} !== {exp_bin == 10'd783 ? 10'd0 : 10'd1023, 1'b1})
      $display("FAIL edge_1024: bin=%0d ovf=%0b", bin_out, ovf);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    int lat;
    out_ready = 1'b0;
    start_conv(16'h12A4, lat);
    total_cnt++;
    if ({bin_out, ovf, err} !== {10'd0, 1'b0, 1'b1})
      $display("FAIL error_digit: bin=%0d ovf=%0b err=%0b want 0/0/1", bin_out, ovf, err);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    // error must not stick into the next conversion
    out_ready = 1'b0;
    start_conv(16'h0007, lat);
    total_cnt++;
    if ({bin_out, err} !== {10'd7, 1'b0})
      $display("FAIL error_clear: bin=%0d err=%0b want 7/0", bin_out, err);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    out_ready = 1'b0;
    start_conv(16'h0321, lat);
    bcd_in   = 16'h0555;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && bin_out === 10'd321 && in_ready === 1'b0)) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL hold_stable: %0d bad cycles, bin=%0d want 321", bad, bin_out);
    else pass_cnt++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready, bin_out} !== {1'b0, 1'b1, 10'd321})
      $display("FAIL hold_no_accept: valid=%0b ready=%0b bin=%0d want 0/1/321", out_valid, in_ready, bin_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bcd_in   = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, ovf, err, bin_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 10'd0})
      $display("FAIL reset_mid: valid=%0b ready=%0b bin=%0d want 0/1/0", out_valid, in_ready, bin_out);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b0;
    start_conv(16'h0042, lat);
    total_cnt++;
    if ({lat, bin_out} !== {32'd5, 10'd42})
      $display("FAIL reset_recover: lat=%0d bin=%0d want 5/42", lat, bin_out);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    start_conv(16'h0000, lat);
    total_cnt++;
    if ({bin_out, ovf, err} !== {10'd0, 1'b0, 1'b0})
      $display("FAIL b2b_first: bin=%0d want 0", bin_out);
    else pass_cnt++;
    bcd_in   = 16'h0999;
    in_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL b2b_handshake: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL b2b_accept: ready=%0b want 0", in_ready);
    else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if ({lat, bin_out} !== {32'd5, 10'd999})
      $display("FAIL b2b_second: lat=%0d bin=%0d want 5/999", lat, bin_out);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_error();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
